// File: rtl/tag_lookup_ctrl_if.sv
// Bundles the controller's three busses: CPU request/response, memory refill
// handshake and the tag RAM port. master = controller side, slave = environment.
interface tag_lookup_ctrl_if #(
  parameter int TAG_W   = 20,
  parameter int INDEX_W = 6
);
  localparam int ADDR_W = TAG_W + INDEX_W;

  logic              ReqValid;
  logic              ReqReady;
  logic [ADDR_W-1:0] ReqAddr;
  logic              RespValid;
  logic              RespHit;
  logic              MemReq;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemAck;
  logic [INDEX_W-1:0] TagAddr;
  logic [TAG_W-1:0]  TagWrData;
  logic              TagWrite;
  logic [TAG_W-1:0]  TagRdData;

  modport master (
    input  ReqValid, ReqAddr, MemAck, TagRdData,
    output ReqReady, RespValid, RespHit, MemReq, MemAddr,
           TagAddr, TagWrData, TagWrite
  );

  modport slave (
    output ReqValid, ReqAddr, MemAck, TagRdData,
    input  ReqReady, RespValid, RespHit, MemReq, MemAddr,
           TagAddr, TagWrData, TagWrite
  );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// Tag lookup controller: reads the tag RAM, compares against a local valid
// array, reports hit/miss and runs a refill handshake on a miss.
module tag_lookup_ctrl #(
  parameter int TAG_W     = 20,
  parameter int INDEX_W   = 6,
  parameter int CACHESIZE = 64,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  tag_lookup_ctrl_if.master bus,
  output logic [CNT_W-1:0] HitCount,
  output logic [CNT_W-1:0] MissCount,
  output logic [2:0]       StateDbg
);
  localparam int ADDR_W = TAG_W + INDEX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    COMPARE = 3'd2,
    MISS    = 3'd3,
    FILL    = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t               state;
  logic [CACHESIZE-1:0] validQ;
  logic [ADDR_W-1:0]    reqAddrQ;
  logic                 flushPend;
  logic                 respValid;
  logic                 respHit;
  logic                 memReq;
  logic                 tagWrite;

  logic [INDEX_W-1:0]   reqIndex;
  logic [TAG_W-1:0]     reqTag;
  logic                 lookupHit;

  assign reqIndex  = reqAddrQ[INDEX_W-1:0];
  assign reqTag    = reqAddrQ[ADDR_W-1:INDEX_W];
  assign lookupHit = validQ[reqIndex] && (bus.TagRdData == reqTag);

  // Request handshake: a request transfers on a posedge where ReqValid and
  // ReqReady are both high; the requester holds ReqValid/ReqAddr until then.
  // ReqReady never depends on ReqValid. Refill: MemReq stays high until
  // MemAck is sampled high, and drops on that same edge.
  assign bus.ReqReady  = (state == IDLE) && !flushPend && !Flush;
  assign bus.RespValid = respValid;
  assign bus.RespHit   = respHit;
  assign bus.MemReq    = memReq;
  assign bus.MemAddr   = reqAddrQ;
  assign bus.TagAddr   = reqIndex;
  assign bus.TagWrData = reqTag;
  assign bus.TagWrite  = tagWrite;
  assign StateDbg      = state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      validQ    <= '0;
      reqAddrQ  <= '0;
      flushPend <= 1'b0;
      respValid <= 1'b0;
      respHit   <= 1'b0;
      memReq    <= 1'b0;
      tagWrite  <= 1'b0;
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      // A flush seen mid-lookup is remembered and applied once back in IDLE.
      if (Flush && (state != IDLE)) flushPend <= 1'b1;

      unique case (state)
        IDLE: begin
          if (flushPend || Flush) begin
            validQ    <= '0;
            flushPend <= 1'b0;
          end else if (bus.ReqValid) begin
            reqAddrQ <= bus.ReqAddr;
            state    <= READ;
          end
        end
        READ: state <= COMPARE;
        COMPARE: begin
          if (lookupHit) begin
            respHit   <= 1'b1;
            respValid <= 1'b1;
            if (HitCount != '1) HitCount <= HitCount + CNT_ONE;
            state <= RESP;
          end else begin
            if (MissCount != '1) MissCount <= MissCount + CNT_ONE;
            memReq <= 1'b1;
            state  <= MISS;
          end
        end
        MISS: begin
          if (bus.MemAck) begin
            memReq   <= 1'b0;
            tagWrite <= 1'b1;
            state    <= FILL;
          end
        end
        FILL: begin
          tagWrite         <= 1'b0;
          validQ[reqIndex] <= 1'b1;
          respHit          <= 1'b0;
          respValid        <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          respValid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/tag_lookup_ctrl.md
Name: tag_lookup_ctrl

Overview:
- Requester-side controller that drives the cache tag RAM: owns its address, write-data and write-enable, and consumes its registered read data.
- Accepts CPU lookup requests, reads the tag, compares it with the request and a valid-bit array kept in this block, and reports hit or miss.
- On a miss it runs a refill handshake with the memory side, then writes the new tag and sets the valid bit.
- Sits between the CPU request port and the tag RAM, alongside the data-RAM path.

Parameters:
- TAG_W, 20, tag field width (request address [ADDR_W-1:INDEX_W])
- INDEX_W, 6, index field width (request address [INDEX_W-1:0])
- CACHESIZE, 64, number of lines; equals 2**INDEX_W
- CNT_W, 16, hit and miss counter width

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  lookup request present.
- ReqReady  out  1  controller can accept a request.
- ReqAddr  in  TAG_W+INDEX_W  request address.
- Flush  in  1  invalidate all lines (level, sampled each posedge).
- RespValid  out  1  one-cycle response strobe.
- RespHit  out  1  1 = hit, 0 = miss (refilled); valid only with RespValid.
- MemReq  out  1  refill request to memory side.
- MemAddr  out  TAG_W+INDEX_W  refill address (latched request address).
- MemAck  in  1  refill complete.
- TagAddr  out  INDEX_W  to tag RAM Address.
- TagWrData  out  TAG_W  to tag RAM TagIn.
- TagWrite  out  1  to tag RAM Write.
- TagRdData  in  TAG_W  from tag RAM TagOut; registered on posedge, 1-cycle latency.
- HitCount  out  CNT_W  saturating hit counter.
- MissCount  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (async):
  - State goes to IDLE; valid array all 0; request latch, HitCount and MissCount are 0.
  - RespValid, RespHit, MemReq, TagWrite and the flush-pending flag are 0.
  - Tag RAM contents are not touched.
- Request latch: captures ReqAddr on an accept. TagAddr = latched index at all times; TagWrData = latched tag at all times; MemAddr = latched address.
- FSM states: IDLE, READ, COMPARE, MISS, FILL, RESP.
- IDLE:
  - ReqReady = 1 only when no flush is pending and Flush = 0.
  - Accept = ReqValid & ReqReady; latches the address and goes to READ.
  - If a flush is pending or Flush = 1: clear all valid bits this posedge, clear the pending flag, accept nothing, stay in IDLE.
- READ: one cycle. The tag RAM captures TagAddr at the closing posedge. Go to COMPARE.
- COMPARE:
  - hit = valid[index] & (TagRdData == latched tag).
  - Hit: set RespHit = 1, increment HitCount, go to RESP.
  - Miss: increment MissCount, go to MISS.
- MISS:
  - MemReq = 1 (registered, set on entry) and held until MemAck is sampled high.
  - On MemAck: MemReq = 0 at the same edge, go to FILL.
  - MemAck outside MISS is ignored.
- FILL:
  - TagWrite = 1 for exactly this one cycle; the tag RAM writes on the mid-cycle negedge.
  - valid[index] is set at the closing posedge; RespHit = 0; go to RESP.
- RESP: RespValid = 1 for one cycle, RespHit held; return to IDLE. RespValid and RespHit are registered Moore outputs.
- Latency:
  - Hit: accept edge E, RespValid high in cycle E+3.
  - Miss: RespValid high 2 cycles after the edge where MemAck is sampled.
- Counters saturate at all-ones and do not wrap.
- Flush outside IDLE: sets the sticky pending flag and does not disturb the in-flight lookup; the clear is applied on the first IDLE cycle. A flush that overlaps a FILL therefore also clears the newly set bit.
- ReqValid while ReqReady = 0 is not captured; the requester must hold it.
- TagWrite is 0 in every state except FILL.

Test Plan:
- Reset, then request 0x00ABC_05 -> miss. MemReq rises in cycle E+3. MemAck pulses 4 cycles later -> one TagWrite cycle with TagAddr = 5, TagWrData = 0x00ABC. Then RespValid = 1, RespHit = 0; MissCount = 1.
- Repeat the same address -> RespValid in cycle E+3 with RespHit = 1, no MemReq, HitCount = 1.
- Same index 5, tag 0x00ABD -> miss and refill; a following request to 0x00ABC_05 misses again (tag replaced).
- Flush asserted during MISS of a request to index 7 -> refill completes with RespHit = 0. The first IDLE cycle clears valid with ReqReady = 0; a re-request to index 7 then misses.
- Assert Reset while in MISS with MemReq = 1 -> MemReq, RespValid and the counters go to 0 immediately. A request to a previously filled line then misses.
- Preload HitCount to all-ones via 2**CNT_W hits (or a forced value) -> a further hit leaves HitCount at 0xFFFF.
